idelay_tap_loader: RTL and testbench
====================================

# idelay_tap_loader

Control-side initiator for the ADC input-delay lanes. It accepts per-lane tap-write commands, drives the shared count-value bus plus a one-hot load strobe into the per-lane IDELAY wrappers, and waits out their input and output register pipelines. It then reads the lane's count-value output back and returns a checked response with a bounded number of retries. It sits between the register or bitslip-calibration logic and the array of delay wrappers, all in the `clk_div` domain.

## Interface
Parameters:
- `NUM_LANES`, 16, number of delay-wrapper lanes driven.
- `LANE_W`, `$clog2(NUM_LANES)`, width of the lane index.
- `SETTLE_CYCLES`, 8, wait after the load pulse before readback; must be ≥ 6.
- `MAX_RETRY`, 2, extra load attempts after a readback mismatch.
- `TAP_MAX`, 511, highest legal tap value.

Ports:
- `clk_div` in 1: only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both `cmd_valid` and `cmd_ready` are high at an edge.
- `cmd_lane` in `LANE_W`: target lane.
- `cmd_tap` in 9: tap value to load.
- `dly_load` out `NUM_LANES`: one-hot load pulse, bit i goes to the `load` input of lane i.
- `dly_cntvaluein` out 9: shared count-value-in bus to all lanes.
- `dly_cntvalueout` in `NUM_LANES*9`: concatenated readback; lane i occupies `[9i+8:9i]`.
- `rsp_valid` out 1: response available, held high until accepted.
- `rsp_ready` in 1: response accept.
- `rsp_lane` out `LANE_W`: lane of the response.
- `rsp_tap` out 9: last readback value, or 0 if no load was issued.
- `rsp_err` out 1: 1 means illegal command or persistent mismatch.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, LOAD, WAIT, CHECK, RESP.
- **IDLE**: `cmd_ready` = 1. On accept, latch `cmd_lane` and `cmd_tap` and clear the retry count.
  - If `lane ≥ NUM_LANES` or `tap > TAP_MAX`, go to RESP with `rsp_err` = 1 and `rsp_tap` = 0. No load is issued.
  - Otherwise go to SETUP.
- **SETUP**: drive `dly_cntvaluein` = tap. `dly_load` = 0.
- **LOAD**: `dly_load[lane]` = 1 for exactly one cycle. `dly_cntvaluein` stays held.
- **WAIT**: count `SETTLE_CYCLES` cycles. `dly_cntvaluein` stays held, so it is stable from SETUP through CHECK.
- **CHECK**: compare the selected readback slice with tap.
  - Equal: go to RESP with `rsp_err` = 0.
  - Unequal and retries < `MAX_RETRY`: increment retries and go to SETUP.
  - Unequal and retries exhausted: go to RESP with `rsp_err` = 1.
- **RESP**: `rsp_valid` = 1 and `rsp_*` are stable. When `rsp_valid` and `rsp_ready` are both high, go to IDLE.
- `dly_cntvaluein` returns to 0 in IDLE.
- Never more than one `dly_load` bit is high at once, and never for two consecutive cycles.

## Timing
- **Reset** (`rst_n` low at an edge): the next cycle shows state IDLE, and all outputs are 0, including `cmd_ready`.
  - `cmd_ready` = 1 from the first cycle with `rst_n` high.
  - Reset mid-operation aborts immediately: the load pulse is cut and any pending response is discarded.
- **Readback path**: the delay wrapper adds 2 register stages on load and value, the primitive updates on the next edge, and 2 stages are added on readback. Valid readback therefore appears 5 cycles after the LOAD cycle, which is why `SETTLE_CYCLES` ≥ 6.
- **Good command latency**: `rsp_valid` rises `SETTLE_CYCLES`+4 cycles after the accept edge, i.e. 12 at the default.
  - Each retry adds `SETTLE_CYCLES`+3 cycles.
- **Illegal command latency**: `rsp_valid` rises 1 cycle after accept.
- **Back-to-back commands**: the earliest next accept is the cycle after the response is accepted. With `rsp_ready` tied high, RESP lasts exactly 1 cycle.
- `cmd_*` inputs are sampled only at the accept edge. Later changes are ignored.

## Structure
- Shared package `idelay_pkg` holds:
  - `TAP_W` = 9;
  - the FSM state enum;
  - `DELAY_PIPE_LAT` = 5 (delay-wrapper round-trip latency);
  - the minimum-settle constant, used in an elaboration check that `SETTLE_CYCLES` ≥ `DELAY_PIPE_LAT`+1.
- No sub-module. The readback slice mux, settle counter and retry counter are inline.
- The bench provides a behavioural lane model with 2 input register stages, a tap register and 2 output register stages. It can optionally corrupt the loaded value N times.

## Test plan
- Reset, then `cmd` lane 3, tap 100 with `rsp_ready` = 1:
  - `dly_load` = `0x0008` for one cycle, 2 cycles after accept;
  - `rsp_valid` 12 cycles after accept, with `rsp_tap` = 100, `rsp_err` = 0.
- `cmd` lane 16 (with `NUM_LANES` = 16), or tap 512 when `TAP_MAX` = 511:
  - no `dly_load` activity;
  - `rsp_err` = 1, `rsp_tap` = 0, `rsp_valid` 1 cycle after accept.
- Lane model corrupts the first 2 loads of lane 5, tap 37:
  - 3 load pulses;
  - `rsp_err` = 0, `rsp_tap` = 37 at 12 + 2×11 = 34 cycles.
- Lane model always corrupts:
  - 3 load pulses;
  - `rsp_err` = 1, `rsp_tap` equals the corrupted value.
- `rsp_ready` held low for 20 cycles:
  - `rsp_*` stable and `cmd_ready` = 0 throughout;
  - after `rsp_ready` is raised, `cmd_ready` = 1 on the next cycle.
- `rst_n` pulled low during WAIT:
  - next cycle all outputs are 0;
  - no response is produced;
  - a new command then completes normally in 12 cycles.

Source files
------------

// File: rtl/idelay_pkg.sv
// Shared constants and FSM state type for the IDELAY tap-loader control path.
package idelay_pkg;

   localparam int unsigned TAP_W             = 9;
   localparam int unsigned DELAY_PIPE_LAT    = 5;
   // Readback must be stable one cycle before CHECK samples it.
   localparam int unsigned MIN_SETTLE_CYCLES = DELAY_PIPE_LAT + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LOAD,
      ST_WAIT,
      ST_CHECK,
      ST_RESP
   } state_e;

endpackage

// File: rtl/idelay_tap_loader.sv
// Loads a tap value into one IDELAY lane, waits out the wrapper pipeline and
// verifies the readback, retrying a bounded number of times on mismatch.
module idelay_tap_loader
   import idelay_pkg::*;
#(
   parameter int unsigned NUM_LANES     = 16,
   parameter int unsigned LANE_W        = $clog2(NUM_LANES),
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned MAX_RETRY     = 2,
   parameter int unsigned TAP_MAX       = 511
) (
   input  logic                       clk_div,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [LANE_W-1:0]          cmd_lane,
   input  logic [TAP_W-1:0]           cmd_tap,
   output logic [NUM_LANES-1:0]       dly_load,
   output logic [TAP_W-1:0]           dly_cntvaluein,
   input  logic [NUM_LANES*TAP_W-1:0] dly_cntvalueout,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [LANE_W-1:0]          rsp_lane,
   output logic [TAP_W-1:0]           rsp_tap,
   output logic                       rsp_err,
   output logic                       busy
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   if (SETTLE_CYCLES < MIN_SETTLE_CYCLES) begin : g_bad_settle
      $error("SETTLE_CYCLES must cover the delay-wrapper round trip");
   end

   state_e              state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [TAP_W-1:0]    tap_q, tap_d;
   logic [TAP_W-1:0]    rtap_q, rtap_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RTY_W-1:0]    rty_q, rty_d;
   logic [TAP_W-1:0]    readback;
   logic                cmd_illegal;

   assign cmd_illegal = (32'(cmd_lane) >= NUM_LANES) || (32'(cmd_tap) > TAP_MAX);

   always_comb begin
      readback = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (32'(lane_q) == i) readback = dly_cntvalueout[i*TAP_W +: TAP_W];
      end
   end

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      tap_d   = tap_q;
      rtap_d  = rtap_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      rty_d   = rty_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               lane_d = cmd_lane;
               tap_d  = cmd_tap;
               rty_d  = '0;
               rtap_d = '0;
               err_d  = 1'b0;
               if (cmd_illegal) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: state_d = ST_LOAD;
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            rtap_d = readback;
            if (readback == tap_q) begin
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (32'(rty_q) < MAX_RETRY) begin
               rty_d   = rty_q + 1'b1;
               state_d = ST_SETUP;
            end else begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_div) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lane_q  <= '0;
         tap_q   <= '0;
         rtap_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         rty_q   <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         tap_q   <= tap_d;
         rtap_q  <= rtap_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         rty_q   <= rty_d;
      end
   end

   // Ready is gated by rst_n so it stays low while reset is still asserted.
   assign cmd_ready = rst_n && (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_lane  = rsp_valid ? lane_q : '0;
   assign rsp_tap   = rsp_valid ? rtap_q : '0;
   assign rsp_err   = rsp_valid && err_q;

   assign dly_cntvaluein = (state_q inside {ST_SETUP, ST_LOAD, ST_WAIT, ST_CHECK}) ? tap_q : '0;

   always_comb begin
      dly_load = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if ((state_q == ST_LOAD) && (32'(lane_q) == i)) dly_load[i] = 1'b1;
      end
   end

endmodule

// File: tb/tb_idelay_tap_loader.sv
// Scoreboard bench for idelay_tap_loader with a behavioural delay-lane model.
module tb_idelay_tap_loader;

   localparam int NL = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [4:0]     cmd_lane = '0;
   logic [8:0]     cmd_tap = '0;
   logic [NL-1:0]  dly_load;
   logic [8:0]     dly_cntvaluein;
   logic [NL*9-1:0] dly_cntvalueout;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic [4:0]     rsp_lane;
   logic [8:0]     rsp_tap;
   logic           rsp_err;
   logic           busy;

   always #5 clk = ~clk;

   idelay_tap_loader #(
      .NUM_LANES(NL), .LANE_W(5), .SETTLE_CYCLES(8), .MAX_RETRY(2), .TAP_MAX(511)
   ) dut (
      .clk_div(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_lane(cmd_lane), .cmd_tap(cmd_tap), .dly_load(dly_load),
      .dly_cntvaluein(dly_cntvaluein), .dly_cntvalueout(dly_cntvalueout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lane(rsp_lane),
      .rsp_tap(rsp_tap), .rsp_err(rsp_err), .busy(busy)
   );

   // Lane model: 2 input stages, tap register, 2 output stages.
   int         corrupt_lane = 99;
   int         corrupt_n = 0;
   bit         corrupt_all = 1'b0;
   int         hit_cnt = 0;
   logic [NL-1:0] ld1 = '0, ld2 = '0;
   logic [8:0] v1 = '0, v2 = '0;
   logic [8:0] tapr [NL] = '{default: '0};
   logic [8:0] o1 [NL] = '{default: '0};
   logic [8:0] o2 [NL] = '{default: '0};

   always @(posedge clk) begin
      ld1 <= dly_load;
      v1  <= dly_cntvaluein;
      ld2 <= ld1;
      v2  <= v1;
      for (int i = 0; i < NL; i++) begin
         if (ld2[i] && i == corrupt_lane) begin
            if (corrupt_all || hit_cnt < corrupt_n) tapr[i] <= v2 ^ 9'h155;
            else tapr[i] <= v2;
            hit_cnt <= hit_cnt + 1;
         end else if (ld2[i]) begin
            tapr[i] <= v2;
         end
      end
      o1 <= tapr;
      o2 <= o1;
   end

   always @* begin
      for (int i = 0; i < NL; i++) dly_cntvalueout[i*9 +: 9] = o2[i];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [4:0]  lane;
      logic [8:0]  cmd_tap;
      logic [8:0]  tap;
      logic        err;
      int          lat;
      int          loads;
      int          load_lat;
      logic [15:0] load_val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_rsp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Monitor: load-pulse rules, response scoreboard, response stability.
   initial begin : monitor
      int          acc_cyc, load_cnt, first_lat;
      logic [15:0] prev_load, first_val;
      bit          rsp_seen;
      exp_t        e;
      logic [4:0]  h_lane;
      logic [8:0]  h_tap;
      logic        h_err;
      acc_cyc = 0; load_cnt = 0; first_lat = -1; prev_load = '0; first_val = '0;
      rsp_seen = 1'b0; h_lane = '0; h_tap = '0; h_err = 1'b0;
      forever begin
         @(negedge clk);
         if (cyc == 0) continue;
         if (!busy) begin
            check("idle_cntvaluein", 32'(dly_cntvaluein), 32'd0);
            check("idle_load", 32'(dly_load), 32'd0);
         end
         if (dly_load != '0) begin
            check("load_onehot", 32'($onehot(dly_load)), 32'd1);
            check("load_not_consecutive", 32'(prev_load), 32'd0);
            if (exp_q.size() > 0) check("load_cntvaluein", 32'(dly_cntvaluein), 32'(exp_q[0].cmd_tap));
            load_cnt++;
            if (load_cnt == 1) begin
               first_lat = cyc - acc_cyc;
               first_val = dly_load;
            end
         end
         prev_load = dly_load;
         if (rsp_valid) begin
            if (!rsp_seen) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 32'(rsp_valid), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_lane", 32'(rsp_lane), 32'(e.lane));
                  check("rsp_tap", 32'(rsp_tap), 32'(e.tap));
                  check("rsp_err", 32'(rsp_err), 32'(e.err));
                  check("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                  check("load_count", 32'(load_cnt), 32'(e.loads));
                  check("rsp_busy", 32'(busy), 32'd1);
                  if (e.load_lat >= 0) begin
                     check("load_latency", 32'(first_lat), 32'(e.load_lat));
                     check("load_value", 32'(first_val), 32'(e.load_val));
                  end
               end
               h_lane = rsp_lane; h_tap = rsp_tap; h_err = rsp_err;
               rsp_seen = 1'b1;
            end else begin
               check("hold_lane", 32'(rsp_lane), 32'(h_lane));
               check("hold_tap", 32'(rsp_tap), 32'(h_tap));
               check("hold_err", 32'(rsp_err), 32'(h_err));
               check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            end
            if (rsp_ready) begin
               rsp_seen = 1'b0;
               n_rsp++;
            end
         end else begin
            rsp_seen = 1'b0;
         end
         if (cmd_valid && cmd_ready) begin
            acc_cyc  = cyc;
            load_cnt = 0;
            first_lat = -1;
         end
      end
   end

   task automatic issue(input logic [4:0] lane, input logic [8:0] tap);
      logic rdy;
      bit   ok;
      ok = 1'b0;
      cmd_lane  = lane;
      cmd_tap   = tap;
      cmd_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         rdy = cmd_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      cmd_lane  = 5'($urandom);
      cmd_tap   = 9'($urandom);
   endtask

   task automatic wait_rsp(input int target);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (n_rsp >= target) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("rsp_timeout", 32'(n_rsp), 32'(target));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_dly_load"}, 32'(dly_load), 32'd0);
      check({tag, "_cntvaluein"}, 32'(dly_cntvaluein), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_lane"}, 32'(rsp_lane), 32'd0);
      check({tag, "_rsp_tap"}, 32'(rsp_tap), 32'd0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
   endtask

   task automatic run_cmd(input exp_t e);
      int target;
      target = n_rsp + 1;
      exp_q.push_back(e);
      issue(e.lane, e.cmd_tap);
      wait_rsp(target);
   endtask

   initial begin : driver
      bit ok;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;

      // Legal commands, including lane/tap boundaries
      run_cmd('{5'd3,  9'd100, 9'd100, 1'b0, 12, 1, 2, 16'h0008});
      run_cmd('{5'd15, 9'd511, 9'd511, 1'b0, 12, 1, 2, 16'h8000});
      run_cmd('{5'd0,  9'd0,   9'd0,   1'b0, 12, 1, 2, 16'h0001});

      // Illegal lanes: no load, immediate error response
      run_cmd('{5'd16, 9'd50,  9'd0, 1'b1, 1, 0, -1, 16'h0000});
      run_cmd('{5'd31, 9'd511, 9'd0, 1'b1, 1, 0, -1, 16'h0000});

      // First two loads of lane 5 corrupted: recovers on the second retry
      corrupt_lane = 5;
      corrupt_all  = 1'b0;
      corrupt_n    = hit_cnt + 2;
      run_cmd('{5'd5, 9'd37, 9'd37, 1'b0, 34, 3, 2, 16'h0020});

      // Persistent corruption: 200 ^ 0x155 = 413
      corrupt_lane = 9;
      corrupt_all  = 1'b1;
      run_cmd('{5'd9, 9'd200, 9'd413, 1'b1, 34, 3, 2, 16'h0200});
      corrupt_all  = 1'b0;
      corrupt_lane = 99;

      // Response held off by rsp_ready low for 20 cycles
      rsp_ready = 1'b0;
      exp_q.push_back('{5'd7, 9'd300, 9'd300, 1'b0, 12, 1, 2, 16'h0080});
      issue(5'd7, 9'd300);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("hold_rsp_timeout", 32'd0, 32'd1);
      repeat (20) @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("hold_release_cmd_ready", 32'(cmd_ready), 32'd1);
      check("hold_release_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;

      // Reset during WAIT aborts the command with no response
      issue(5'd2, 9'd77);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("abort");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      run_cmd('{5'd4, 9'd255, 9'd255, 1'b0, 12, 1, 2, 16'h0010});

      repeat (3) @(posedge clk);
      check("leftover_expected", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
